spi_rx_deserializer: RTL and testbench
======================================

Name: spi_rx_deserializer

Overview:
SPI slave receive path: the serial-in/parallel-out counterpart of the transmit bit selector.
- Samples MOSI on SCLK rising edges while CS_n is low, MSB first.
- Assembles DATA_W-bit words and presents each one with a valid/ack handshake to the register and control logic.
- Runs entirely in the system clock domain. SCLK, CS_n and MOSI are oversampled through synchronizers, so no SCLK-clocked flops are used.

Parameters:
DATA_W, 16, frame length in bits; also the width of rx_data.
SYNC_STAGES, 2, synchronizer depth on spi_sclk, spi_cs_n and spi_mosi; minimum 2.

Ports:
clk  in  1  system clock; frequency must be at least 4x SCLK.
rst  in  1  synchronous, active-high reset.
spi_sclk  in  1  SPI serial clock (asynchronous), CPOL=0/CPHA=0.
spi_cs_n  in  1  chip select, active low (asynchronous).
spi_mosi  in  1  serial data in (asynchronous).
rx_data  out  DATA_W  last complete received word.
rx_valid  out  1  rx_data holds an unread word.
rx_ack  in  1  consumer has read rx_data; clears rx_valid.
busy  out  1  frame in progress (state SHIFT, bit count > 0).

Behaviour:
- Reset: one clk with rst=1 forces the following, regardless of SPI pin activity:
  - rx_data=0, rx_valid=0, busy=0;
  - bit counter=0, shift register=0, state=IDLE, synchronizer flops=1 for cs_n and 0 for sclk and mosi.
- Synchronizers and edge detection:
  - Each input passes through SYNC_STAGES flops.
  - sclk_rise = synced sclk high AND previous synced sclk low (one extra flop).
  - Synced mosi is sampled in the same clk cycle that sclk_rise is detected.
- FSM, two states:
  - IDLE: synced cs_n=1. On synced cs_n=0, go to SHIFT and clear the bit counter.
  - SHIFT: on each sclk_rise:
    - shift register <= {shift[DATA_W-2:0], mosi};
    - counter <= counter+1.
  - Counter width is $clog2(DATA_W). It wraps from DATA_W-1 to 0.
- Word completion: sclk_rise while counter==DATA_W-1.
  - rx_data <= {shift[DATA_W-2:0], mosi} and rx_valid <= 1, both visible on the next clk edge.
  - Counter wraps to 0 and state stays SHIFT, so back-to-back frames work with CS held low.
- Latency: rx_valid rises SYNC_STAGES+2 clk cycles after the final SCLK pin rising edge.
- CS deassert (synced cs_n=1) in SHIFT:
  - Go to IDLE and clear the counter.
  - A partial word is discarded; rx_data and rx_valid are unchanged.
  - A sclk_rise in the same cycle as cs_n rising is ignored.
- Handshake:
  - rx_ack=1 clears rx_valid on the next clk.
  - If completion and rx_ack occur in the same cycle, completion wins: rx_valid stays 1 with the new data.
  - rx_ack while rx_valid=0 has no effect.
- Unread word: without the optional feature, a new completion overwrites rx_data and rx_valid stays 1.
- SCLK edges while in IDLE are ignored.

Optional Feature:
SPI_RX_OVERRUN_EN
- Defined:
  - Adds output rx_overrun (1 bit, reset 0).
  - A completion while rx_valid=1 and rx_ack=0 sets rx_overrun. The new word is dropped and rx_data keeps the unread word.
  - rx_overrun is sticky; it clears only on rx_ack or rst.
- Undefined: the port is absent and the overwrite rule applies.

Decomposition:
- Package spi_pkg holds:
  - localparam SPI_DATA_W=16;
  - typedef enum logic {RX_IDLE, RX_SHIFT} spi_rx_state_t;
  - function clog2-based counter width.
- Sub-module spi_sync_edge: one instance per input. It contains the SYNC_STAGES synchronizer plus rise and fall detect, with outputs q, rise and fall. Only the sclk instance uses rise.

Test Plan:
- Reset, then CS low, shift 0xA55A MSB first, CS high → rx_data=0xA55A; rx_valid=1 SYNC_STAGES+2 clks after the 16th SCLK edge; busy low afterwards.
- CS held low, frames 0x1234 then 0xBEEF, rx_ack pulsed between them → two valid events, rx_data=0x1234 then 0xBEEF.
- CS low, 7 bits of 0xFFFF, CS high, then full frame 0x00FF → only one completion, rx_data=0x00FF, no corrupted word.
- rst=1 asserted after 9 bits of 0xCAFE, then released, then full frame 0x0F0F → all outputs 0 during reset; next word 0x0F0F.
- Completion of 0x5555 in the same cycle as rx_ack for prior 0x1111 → rx_valid stays 1, rx_data=0x5555.
- With SPI_RX_OVERRUN_EN: 0x1111 left unacked, then 0x2222 received → rx_data=0x1111, rx_overrun=1; rx_ack clears both flags. Without the macro: rx_data=0x2222.

Source files
------------

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI slave receive path.
//   SPI_DATA_W      : default frame length in bits
//   spi_rx_state_t  : receive FSM state encoding
//   spi_cnt_w()     : width of a bit counter that spans 0..w-1
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_DATA_W = 16;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } spi_rx_state_t;

  // Bit counter width for a w-bit frame; never narrower than one bit.
  function automatic int spi_cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous SPI pin into the clk domain and flags its edges.
// Ports:
//   clk   : system clock
//   rst   : synchronous active-high reset (chain loads RST_VAL)
//   d     : asynchronous pin
//   q     : synchronized level, aligned with rise/fall
//   rise  : one-clk pulse, q went 0->1 this cycle
//   fall  : one-clk pulse, q went 1->0 this cycle
// q, rise and fall are all registered, so a consumer sampling a data pin's q
// in the cycle rise is high sees that pin as it was at the same instant.
// ---------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;
  logic              rise_q;
  logic              fall_q;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) sync_q[gi] <= RST_VAL;
          else     sync_q[gi] <= d;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (rst) sync_q[gi] <= RST_VAL;
          else     sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  // The extra flop holds the previous synchronized level; edge flags are
  // registered alongside it so every output changes on the same clk edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      last_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~last_q;
      fall_q <= ~sync_q[STAGES-1] & last_q;
    end
  end

  assign q    = last_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_rx_deserializer.sv
// ---------------------------------------------------------------------------
// spi_rx_deserializer
// SPI slave (CPOL=0/CPHA=0) receive path, fully in the clk domain.
// MOSI is sampled MSB first on synchronized SCLK rising edges while CS_n is
// low; each DATA_W-bit word is handed over with a valid/ack handshake.
// Ports:
//   clk, rst   : system clock (>= 4x SCLK), synchronous active-high reset
//   spi_sclk   : SPI clock pin (async)
//   spi_cs_n   : chip select pin, active low (async)
//   spi_mosi   : serial data pin (async)
//   rx_data    : last complete word
//   rx_valid   : rx_data holds an unread word
//   rx_ack     : consumer has read rx_data
//   busy       : frame in progress (SHIFT with at least one bit received)
//   rx_overrun : only with SPI_RX_OVERRUN_EN; sticky, set when a word
//                completes while the previous one is still unread
// Build option: define SPI_RX_OVERRUN_EN to keep unread words and flag
// overruns instead of overwriting rx_data.
// ---------------------------------------------------------------------------
module spi_rx_deserializer
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              busy
`ifdef SPI_RX_OVERRUN_EN
  ,
  output logic              rx_overrun
`endif
);

  localparam int CNT_W = spi_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic sclk_q, sclk_rise, sclk_fall_unused;
  logic cs_n_q, cs_rise_unused, cs_fall_unused;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk (clk), .rst (rst), .d (spi_sclk),
    .q (sclk_q), .rise (sclk_rise), .fall (sclk_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk (clk), .rst (rst), .d (spi_cs_n),
    .q (cs_n_q), .rise (cs_rise_unused), .fall (cs_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk), .rst (rst), .d (spi_mosi),
    .q (mosi_q), .rise (mosi_rise_unused), .fall (mosi_fall_unused)
  );

  logic sclk_level_unused;
  assign sclk_level_unused = sclk_q;

  spi_rx_state_t     state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
`ifdef SPI_RX_OVERRUN_EN
  logic              rx_overrun_q;
`endif

  assign shift_d = {shift_q[DATA_W-2:0], mosi_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
`ifdef SPI_RX_OVERRUN_EN
      rx_overrun_q <= 1'b0;
`endif
    end else begin
      // Ack is handled first so that a completion later in this block wins.
      if (rx_ack) begin
        rx_valid_q   <= 1'b0;
`ifdef SPI_RX_OVERRUN_EN
        rx_overrun_q <= 1'b0;
`endif
      end

      case (state_q)
        RX_IDLE: begin
          if (!cs_n_q) begin
            state_q <= RX_SHIFT;
            cnt_q   <= '0;
          end
        end

        RX_SHIFT: begin
          // CS release takes priority: a coincident SCLK edge is dropped
          // along with any partial word.
          if (cs_n_q) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
          end else if (sclk_rise) begin
            shift_q <= shift_d;
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
`ifdef SPI_RX_OVERRUN_EN
              if (rx_valid_q && !rx_ack) begin
                rx_overrun_q <= 1'b1;
              end else begin
                rx_data_q  <= shift_d;
                rx_valid_q <= 1'b1;
              end
`else
              rx_data_q  <= shift_d;
              rx_valid_q <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= RX_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q == RX_SHIFT) && (cnt_q != '0);
`ifdef SPI_RX_OVERRUN_EN
  assign rx_overrun = rx_overrun_q;
`endif

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// ---------------------------------------------------------------------------
// tb_spi_rx_deserializer
// Directed and random SPI frames against a word-level model of the
// receiver: every full frame sent with CS low is one completion event,
// partial frames and idle SCLK activity change nothing, ack clears valid.
// Build option: SPI_RX_OVERRUN_EN selects the keep-and-flag model.
// ---------------------------------------------------------------------------
module tb_spi_rx_deserializer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         spi_sclk = 1'b0;
  logic         spi_cs_n = 1'b1;
  logic         spi_mosi = 1'b0;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ack = 1'b0;
  logic         busy;
`ifdef SPI_RX_OVERRUN_EN
  logic         rx_overrun;
`endif

  int checks = 0;
  int errors = 0;

  // Word-level reference state.
  logic [W-1:0] exp_data  = '0;
  logic         exp_valid = 1'b0;
  logic         exp_ovr   = 1'b0;

  spi_rx_deserializer #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .busy     (busy)
`ifdef SPI_RX_OVERRUN_EN
    ,
    .rx_overrun (rx_overrun)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic exp_busy);
    chk({tag, ".rx_data"}, 32'(rx_data), 32'(exp_data));
    chk({tag, ".rx_valid"}, 32'(rx_valid), 32'(exp_valid));
    chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
`ifdef SPI_RX_OVERRUN_EN
    chk({tag, ".rx_overrun"}, 32'(rx_overrun), 32'(exp_ovr));
`endif
    $display("txn %-12s data=%h valid=%0d busy=%0d", tag, rx_data, rx_valid, busy);
  endtask

  // Model: one received word, optionally with ack in the completion cycle.
  task automatic model_word(input logic [W-1:0] w, input bit ack_same);
`ifdef SPI_RX_OVERRUN_EN
    if (exp_valid && !ack_same) begin
      exp_ovr = 1'b1;
    end else begin
      exp_data  = w;
      exp_valid = 1'b1;
      exp_ovr   = 1'b0;
    end
`else
    exp_data  = w;
    exp_valid = 1'b1;
`endif
  endtask

  task automatic do_ack();
    @(negedge clk); rx_ack = 1'b1;
    @(negedge clk); rx_ack = 1'b0;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk); spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk); spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Sends the first nbits of w MSB first. SCLK rises on a clk falling edge,
  // so rx_valid must still be low after the 3rd following posedge and high
  // after the 4th (SYNC_STAGES+2). ack_done pulses rx_ack on that 4th edge.
  task automatic send_word(input logic [W-1:0] w, input int nbits,
                           input bit lat_chk, input bit ack_done);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); spi_mosi = w[W-1-i];
      repeat (2) @(negedge clk);
      spi_sclk = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (i == nbits - 1) begin
          if (k == 3) begin
            if (lat_chk) chk("latency.early", 32'(rx_valid), 32'd0);
            if (ack_done) rx_ack = 1'b1;
          end
          if (k == 4) begin
            rx_ack = 1'b0;
            if (lat_chk) chk("latency.on", 32'(rx_valid), 32'd1);
          end
        end
      end
      spi_sclk = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    logic [W-1:0] rw;

    // Reset
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs("reset", 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame with latency check
    cs_low();
    send_word(16'hA55A, W, 1'b1, 1'b0);
    model_word(16'hA55A, 1'b0);
    cs_high();
    chk_outputs("a55a", 1'b0);
    do_ack();
    chk_outputs("ack_a55a", 1'b0);

    // Back-to-back frames, CS held low
    cs_low();
    send_word(16'h1234, W, 1'b0, 1'b0);
    model_word(16'h1234, 1'b0);
    chk_outputs("b2b_1234", 1'b0);
    do_ack();
    chk_outputs("b2b_ack", 1'b0);
    send_word(16'hBEEF, W, 1'b0, 1'b0);
    model_word(16'hBEEF, 1'b0);
    chk_outputs("b2b_beef", 1'b0);
    cs_high();
    do_ack();

    // Aborted partial frame, then a clean one
    cs_low();
    send_word(16'hFFFF, 7, 1'b0, 1'b0);
    chk_outputs("partial", 1'b1);
    cs_high();
    chk_outputs("abort", 1'b0);
    cs_low();
    send_word(16'h00FF, W, 1'b0, 1'b0);
    model_word(16'h00FF, 1'b0);
    chk_outputs("after_abort", 1'b0);
    cs_high();

    // SCLK activity with CS high is ignored
    send_word(16'hFFFF, W, 1'b0, 1'b0);
    chk_outputs("idle_sclk", 1'b0);

    // Reset mid-frame with CS still low
    cs_low();
    send_word(16'hCAFE, 9, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    exp_data = '0; exp_valid = 1'b0; exp_ovr = 1'b0;
    chk_outputs("mid_reset", 1'b0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    send_word(16'h0F0F, W, 1'b0, 1'b0);
    model_word(16'h0F0F, 1'b0);
    chk_outputs("post_reset", 1'b0);
    cs_high();
    do_ack();

    // Completion coincides with ack of the previous word
    cs_low();
    send_word(16'h1111, W, 1'b0, 1'b0);
    model_word(16'h1111, 1'b0);
    chk_outputs("pre_5555", 1'b0);
    send_word(16'h5555, W, 1'b0, 1'b1);
    model_word(16'h5555, 1'b1);
    chk_outputs("ack_collide", 1'b0);
    cs_high();
    do_ack();

    // Unread word followed by another completion
    cs_low();
    send_word(16'h1111, W, 1'b0, 1'b0);
    model_word(16'h1111, 1'b0);
    send_word(16'h2222, W, 1'b0, 1'b0);
    model_word(16'h2222, 1'b0);
    chk_outputs("unread", 1'b0);
    do_ack();
    chk_outputs("unread_ack", 1'b0);
    cs_high();

    // Random frames with random acks, CS held low
    cs_low();
    for (int n = 0; n < 6; n++) begin
      rw = W'($urandom);
      if ($urandom_range(1, 0) == 1) do_ack();
      send_word(rw, W, 1'b0, 1'b0);
      model_word(rw, 1'b0);
      chk_outputs("random", 1'b0);
    end
    cs_high();
    chk_outputs("random_end", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
